inverse_park_transform: RTL and testbench

Converts the rotating-frame voltage commands Ud/Uq from the current-loop PI into stationary-frame Ualpha/Ubeta for the SVPWM stage, using sin/cos of the electrical angle supplied by the angle/sine generator. One signed 16x16 multiplier is time-shared over four cycles. Each calculation is started by a rising edge of a strobe and ends with a one-cycle done pulse, matching the PI stage's handshake.

---
 rtl/inverse_park_transform.sv | 115 +++++++++++
 tb/tb_inverse_park_transform.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inverse_park_transform.sv
// Inverse Park transform: Ualpha = Ud*cos - Uq*sin, Ubeta = Ud*sin + Uq*cos.
// One 16x16 signed multiplier is shared over four cycles, started by a rising edge of iCal_en.
module inverse_park_transform (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iCal_en,
  input  logic signed [15:0] iUd,
  input  logic signed [15:0] iUq,
  input  logic signed [15:0] iSin,
  input  logic signed [15:0] iCos,
  output logic signed [15:0] oUalpha,
  output logic signed [15:0] oUbeta,
  output logic               oBusy,
  output logic               oCal_done
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, OUT} state_t;

  state_t             state, state_nxt;
  logic               cal_en_q;
  logic               start;
  logic signed [15:0] ud_q, uq_q, sin_q, cos_q;
  logic signed [31:0] mul_a, mul_b;
  logic signed [31:0] product;
  logic signed [32:0] acc_a, acc_b;

  // Q1.15 rescale with floor, clamped symmetrically so -32768 never appears
  function automatic logic signed [15:0] sat(input logic signed [32:0] v);
    logic signed [32:0] s;
    s = v >>> 15;
    if (s >= 33'sd32767)
      sat = 16'sd32767;
    else if (s <= -33'sd32767)
      sat = -16'sd32767;
    else
      sat = s[15:0];
  endfunction

  assign start = iCal_en & ~cal_en_q & (state == IDLE);
  assign oBusy = (state != IDLE) | oCal_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = M0;
      M0:      state_nxt = M1;
      M1:      state_nxt = M2;
      M2:      state_nxt = M3;
      M3:      state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_a = 32'(ud_q);
    mul_b = 32'(cos_q);
    case (state)
      M1: begin
        mul_a = 32'(uq_q);
        mul_b = 32'(sin_q);
      end
      M2: begin
        mul_a = 32'(ud_q);
        mul_b = 32'(sin_q);
      end
      M3: begin
        mul_a = 32'(uq_q);
        mul_b = 32'(cos_q);
      end
      default: ;
    endcase
  end

  // Operands are sign-extended, so the 32-bit product is exact even for (-32768)^2
  assign product = mul_a * mul_b;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      cal_en_q  <= 1'b0;
      ud_q      <= '0;
      uq_q      <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      oUalpha   <= '0;
      oUbeta    <= '0;
      oCal_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cal_en_q  <= iCal_en;
      oCal_done <= (state == OUT);
      if (start) begin
        ud_q  <= iUd;
        uq_q  <= iUq;
        sin_q <= iSin;
        cos_q <= iCos;
      end
      case (state)
        M0:  acc_a <= 33'(product);
        M1:  acc_a <= acc_a - 33'(product);
        M2:  acc_b <= 33'(product);
        M3:  acc_b <= acc_b + 33'(product);
        OUT: begin
          oUalpha <= sat(acc_a);
          oUbeta  <= sat(acc_b);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_park_transform.sv
// Scoreboard bench for inverse_park_transform: expected Ualpha/Ubeta are queued at start
// and compared when the done pulse appears.
module tb_inverse_park_transform;

  logic               iClk;
  logic               iRst_n;
  logic               iCal_en;
  logic signed [15:0] iUd, iUq, iSin, iCos;
  logic signed [15:0] oUalpha, oUbeta;
  logic               oBusy, oCal_done;

  typedef struct {
    int a;
    int b;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;

  inverse_park_transform dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iCal_en  (iCal_en),
    .iUd      (iUd),
    .iUq      (iUq),
    .iSin     (iSin),
    .iCos     (iCos),
    .oUalpha  (oUalpha),
    .oUbeta   (oUbeta),
    .oBusy    (oBusy),
    .oCal_done(oCal_done)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int satRef(input longint v);
    longint s;
    s = v >>> 15;
    if (s >= 32767) return 32767;
    if (s <= -32767) return -32767;
    return int'(s);
  endfunction

  function automatic exp_t model(input int ud, input int uq, input int s, input int c);
    exp_t e;
    e.a = satRef(longint'(ud) * c - longint'(uq) * s);
    e.b = satRef(longint'(ud) * s + longint'(uq) * c);
    return e;
  endfunction

  // Every done pulse seen outside reset is matched against the oldest queued expectation
  always @(negedge iClk) begin
    if (iRst_n && oCal_done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("ualpha", int'(oUalpha), e.a);
        checkOutput("ubeta", int'(oUbeta), e.b);
      end
    end
  end

  task automatic applyStimulus(input int ud, input int uq, input int s, input int c);
    @(negedge iClk);
    iUd     = 16'(ud);
    iUq     = 16'(uq);
    iSin    = 16'(s);
    iCos    = 16'(c);
    iCal_en = 1'b1;
    expQ.push_back(model(int'(iUd), int'(iUq), int'(iSin), int'(iCos)));
    @(negedge iClk);
    iCal_en = 1'b0;
    checkOutput("busy_after_start", int'(oBusy), 1);
  endtask

  // Called right after applyStimulus; done must show on the 5th falling edge
  task automatic waitDone();
    int cycles;
    cycles = 0;
    while (cycles < 20) begin
      @(negedge iClk);
      cycles++;
      if (oCal_done) break;
    end
    if (!oCal_done) begin
      checkOutput("done_timeout", cycles, 5);
    end else begin
      checkOutput("latency", cycles, 5);
      checkOutput("busy_at_done", int'(oBusy), 1);
      @(negedge iClk);
      checkOutput("done_one_cycle", int'(oCal_done), 0);
      checkOutput("busy_after_done", int'(oBusy), 0);
    end
  endtask

  initial begin
    int c0;
    iRst_n  = 1'b0;
    iCal_en = 1'b0;
    iUd = '0; iUq = '0; iSin = '0; iCos = '0;
    repeat (3) @(negedge iClk);
    checkOutput("rst_ualpha", int'(oUalpha), 0);
    checkOutput("rst_ubeta", int'(oUbeta), 0);
    checkOutput("rst_done", int'(oCal_done), 0);
    checkOutput("rst_busy", int'(oBusy), 0);
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);

    applyStimulus(16384, 0, 0, 32767);
    waitDone();
    applyStimulus(0, 10000, 32767, 0);
    waitDone();
    applyStimulus(32767, -32767, 23170, 23170);
    waitDone();
    applyStimulus(-32767, 32767, 23170, 23170);
    waitDone();
    applyStimulus(-32768, 0, 0, -32768);
    waitDone();
    applyStimulus(-32768, -32768, -32768, -32768);
    waitDone();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                    int'($signed(16'($urandom))), int'($signed(16'($urandom))));
      waitDone();
    end

    // Held-high strobe must trigger exactly once
    c0 = doneCount;
    @(negedge iClk);
    iUd = 16'sd1000; iUq = -16'sd2000; iSin = 16'sd12000; iCos = -16'sd9000;
    iCal_en = 1'b1;
    expQ.push_back(model(1000, -2000, 12000, -9000));
    repeat (20) @(negedge iClk);
    iCal_en = 1'b0;
    repeat (5) @(negedge iClk);
    checkOutput("hold_high_pulses", doneCount - c0, 1);

    // Inputs changed during M1 and a second edge during M2 are both ignored
    c0 = doneCount;
    applyStimulus(5000, 7000, -3000, 20000);
    @(negedge iClk);
    iUd = 16'sd30000; iUq = -16'sd30000; iSin = 16'sd30000; iCos = 16'sd30000;
    @(negedge iClk);
    iCal_en = 1'b1;
    @(negedge iClk);
    iCal_en = 1'b0;
    repeat (12) @(negedge iClk);
    checkOutput("ignored_edge_pulses", doneCount - c0, 1);

    // Reset during M3 aborts with no done pulse
    c0 = doneCount;
    applyStimulus(20000, 20000, 20000, 20000);
    repeat (3) @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    expQ.delete();
    checkOutput("midrst_ualpha", int'(oUalpha), 0);
    checkOutput("midrst_ubeta", int'(oUbeta), 0);
    checkOutput("midrst_busy", int'(oBusy), 0);
    checkOutput("midrst_done", int'(oCal_done), 0);
    iRst_n = 1'b1;
    repeat (10) @(negedge iClk);
    checkOutput("midrst_no_pulse", doneCount - c0, 0);
    applyStimulus(-12345, 23456, 30000, -15000);
    waitDone();

    repeat (3) @(negedge iClk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
